// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
package demux_pkg;

  // Routing state: no packet open, or a packet locked to one output.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE0 = 2'd1,
    ROUTE1 = 2'd2
  } state_e;

  // Width of the per-port completed-packet counters (wraps modulo 2**CNT_W).
  localparam int CNT_W = 8;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry register slice: holds a single beat (valid/data/last) and
// accepts a new beat in the same cycle the held one drains.
module demux_out_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_data,
  input  logic             fill_last,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic             can_fill
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  // Next-slot contents: a fill wins over a drain so both in one cycle keep the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (fill) begin
      valid_d = 1'b1;
      data_d  = fill_data;
      last_d  = fill_last;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot register; payload only changes on a fill, so it holds steady while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid    = valid_q;
  assign data     = data_q;
  assign last     = last_q;
  // Room for a new beat: empty now, or the held beat leaves this cycle.
  assign can_fill = !valid_q || ready;

endmodule

// File: rtl/demux1to2_stream.sv
// Packet-aware 1-to-2 stream demultiplexer: the first beat's in_sel picks the
// output, and the rest of the packet follows it regardless of in_sel.
module demux1to2_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             target;
  logic             accept;
  logic             fill0, fill1;
  logic             can_fill0, can_fill1;

  // Target port, input handshake and next state / counter values.
  always_comb begin
    state_d = state_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    case (state_q)
      ROUTE0:  target = 1'b0;
      ROUTE1:  target = 1'b1;
      default: target = in_sel;
    endcase
    in_ready = target ? can_fill1 : can_fill0;
    accept   = in_valid && in_ready;
    fill0    = accept && !target;
    fill1    = accept && target;
    if (accept) begin
      if (in_last) begin
        state_d = IDLE;
        if (target) cnt1_d = cnt1_q + CNT_W'(1);
        else        cnt0_d = cnt0_q + CNT_W'(1);
      end else if (state_q == IDLE) begin
        state_d = target ? ROUTE1 : ROUTE0;
      end
    end
  end

  // Routing state and packet counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

  demux_out_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .fill      (fill0),
    .fill_data (in_data),
    .fill_last (in_last),
    .ready     (out0_ready),
    .valid     (out0_valid),
    .data      (out0_data),
    .last      (out0_last),
    .can_fill  (can_fill0)
  );

  demux_out_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .fill      (fill1),
    .fill_data (in_data),
    .fill_last (in_last),
    .ready     (out1_ready),
    .valid     (out1_valid),
    .data      (out1_data),
    .last      (out1_last),
    .can_fill  (can_fill1)
  );

endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed, table-driven bench for demux1to2_stream.
module tb_demux1to2_stream;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_sel;
  logic       out0_valid, out0_ready, out0_last;
  logic [7:0] out0_data;
  logic       out1_valid, out1_ready, out1_last;
  logic [7:0] out1_data;
  logic [7:0] pkt_cnt0, pkt_cnt1;

  demux1to2_stream #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last),
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the values expected: in_ready before the edge,
  // registered outputs after it.
  typedef struct {
    string      name;
    logic       rst;
    logic       iv;
    logic [7:0] id;
    logic       il;
    logic       is;
    logic       r0;
    logic       r1;
    logic       e_ir;
    logic       e_v0;
    logic [7:0] e_d0;
    logic       e_l0;
    logic       e_v1;
    logic [7:0] e_d1;
    logic       e_l1;
    logic [7:0] e_c0;
    logic [7:0] e_c1;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rst_i, logic iv, logic [7:0] id,
                              logic il, logic is, logic r0, logic r1, logic e_ir,
                              logic e_v0, logic [7:0] e_d0, logic e_l0,
                              logic e_v1, logic [7:0] e_d1, logic e_l1,
                              logic [7:0] e_c0, logic [7:0] e_c1);
    vec_t v;
    v.name = name; v.rst = rst_i; v.iv = iv; v.id = id; v.il = il; v.is = is;
    v.r0 = r0; v.r1 = r1; v.e_ir = e_ir;
    v.e_v0 = e_v0; v.e_d0 = e_d0; v.e_l0 = e_l0;
    v.e_v1 = e_v1; v.e_d1 = e_d1; v.e_l1 = e_l1;
    v.e_c0 = e_c0; v.e_c1 = e_c1;
    return v;
  endfunction

  function automatic logic [35:0] outs_act();
    return {out0_valid, out0_data, out0_last, out1_valid, out1_data, out1_last,
            pkt_cnt0, pkt_cnt1};
  endfunction

  function automatic logic [35:0] outs_exp(vec_t v);
    return {v.e_v0, v.e_d0, v.e_l0, v.e_v1, v.e_d1, v.e_l1, v.e_c0, v.e_c1};
  endfunction

  // Entered just after a rising edge; leaves just after the next rising edge.
  task automatic apply(input vec_t v);
    logic bad;
    logic [35:0] a, e;
    bad = 1'b0;
    rst        = v.rst;
    in_valid   = v.iv;
    in_data    = v.id;
    in_last    = v.il;
    in_sel     = v.is;
    out0_ready = v.r0;
    out1_ready = v.r1;
    @(negedge clk);
    if (in_ready !== v.e_ir) begin
      $display("FAIL %s in_ready: got %b want %b", v.name, in_ready, v.e_ir);
      bad = 1'b1;
    end
    if (v.rst) begin
      a = outs_act();
      e = outs_exp(v);
      if (a !== e) begin
        $display("FAIL %s async-reset outputs: got %h want %h", v.name, a, e);
        bad = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    a = outs_act();
    e = outs_exp(v);
    if (a !== e) begin
      $display("FAIL %s outputs {v0,d0,l0,v1,d1,l1,c0,c1}: got %h want %h", v.name, a, e);
      bad = 1'b1;
    end
    n_vec++;
    if (bad) n_bad++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_sel = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;

    //            name         rst iv id     il is r0 r1 ir  v0 d0     l0 v1 d1     l1 c0     c1
    vecs.push_back(mk("reset",    1, 0, 8'h00, 0, 0, 1, 1, 1,  0, 8'h00, 0, 0, 8'h00, 0, 8'd0, 8'd0));
    vecs.push_back(mk("idle",     0, 0, 8'h00, 0, 0, 1, 1, 1,  0, 8'h00, 0, 0, 8'h00, 0, 8'd0, 8'd0));
    vecs.push_back(mk("single1",  0, 1, 8'hA5, 1, 1, 1, 1, 1,  0, 8'h00, 0, 1, 8'hA5, 1, 8'd0, 8'd1));
    vecs.push_back(mk("drain1",   0, 0, 8'h00, 0, 0, 1, 1, 1,  0, 8'h00, 0, 0, 8'hA5, 1, 8'd0, 8'd1));
    vecs.push_back(mk("lock_b1",  0, 1, 8'h11, 0, 0, 1, 1, 1,  1, 8'h11, 0, 0, 8'hA5, 1, 8'd0, 8'd1));
    vecs.push_back(mk("lock_b2",  0, 1, 8'h22, 0, 1, 1, 1, 1,  1, 8'h22, 0, 0, 8'hA5, 1, 8'd0, 8'd1));
    vecs.push_back(mk("lock_b3",  0, 1, 8'h33, 1, 1, 1, 1, 1,  1, 8'h33, 1, 0, 8'hA5, 1, 8'd1, 8'd1));
    vecs.push_back(mk("drain0",   0, 0, 8'h00, 0, 0, 1, 1, 1,  0, 8'h33, 1, 0, 8'hA5, 1, 8'd1, 8'd1));
    vecs.push_back(mk("bp_b1",    0, 1, 8'h44, 0, 0, 0, 1, 1,  1, 8'h44, 0, 0, 8'hA5, 1, 8'd1, 8'd1));
    vecs.push_back(mk("bp_stall", 0, 1, 8'h55, 1, 0, 0, 1, 0,  1, 8'h44, 0, 0, 8'hA5, 1, 8'd1, 8'd1));
    vecs.push_back(mk("bp_go",    0, 1, 8'h55, 1, 0, 1, 1, 1,  1, 8'h55, 1, 0, 8'hA5, 1, 8'd2, 8'd1));
    vecs.push_back(mk("full0",    0, 0, 8'h00, 0, 0, 0, 1, 0,  1, 8'h55, 1, 0, 8'hA5, 1, 8'd2, 8'd1));
    vecs.push_back(mk("indep1",   0, 1, 8'h66, 1, 1, 0, 1, 1,  1, 8'h55, 1, 1, 8'h66, 1, 8'd2, 8'd2));
    vecs.push_back(mk("swap_st",  0, 0, 8'h00, 0, 0, 1, 0, 1,  0, 8'h55, 1, 1, 8'h66, 1, 8'd2, 8'd2));
    vecs.push_back(mk("full1",    0, 1, 8'h77, 0, 1, 1, 0, 0,  0, 8'h55, 1, 1, 8'h66, 1, 8'd2, 8'd2));
    vecs.push_back(mk("drain1b",  0, 0, 8'h77, 0, 1, 1, 1, 1,  0, 8'h55, 1, 0, 8'h66, 1, 8'd2, 8'd2));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset in the middle of a 4-beat packet to port 1, then a new packet to port 0.
    apply(mk("rm_b1",     0, 1, 8'hB1, 0, 1, 1, 0, 1,  0, 8'h55, 1, 1, 8'hB1, 0, 8'd2, 8'd2));
    apply(mk("rm_b2",     0, 1, 8'hB2, 0, 0, 1, 1, 1,  0, 8'h55, 1, 1, 8'hB2, 0, 8'd2, 8'd2));
    apply(mk("rm_rst",    1, 1, 8'hB3, 0, 1, 1, 0, 1,  0, 8'h00, 0, 0, 8'h00, 0, 8'd0, 8'd0));
    apply(mk("rm_after",  0, 1, 8'hC3, 1, 0, 1, 1, 1,  1, 8'hC3, 1, 0, 8'h00, 0, 8'd1, 8'd0));

    // 255 more single-beat packets to port 0: 256 since reset, so the counter wraps to 0.
    for (int k = 1; k <= 255; k++) begin
      logic [7:0] kd;
      logic [7:0] ec;
      kd = 8'(k);
      ec = 8'(k + 1);
      apply(mk("wrap", 0, 1, kd, 1, 0, 1, 1, 1,  1, kd, 1, 0, 8'h00, 0, ec, 8'd0));
    end
    apply(mk("wrap_end",  0, 0, 8'h00, 0, 0, 1, 1, 1,  0, 8'hFF, 1, 0, 8'h00, 0, 8'd0, 8'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/demux1to2_stream.md
DEMUX1TO2_STREAM -- requirements
Module: demux1to2_stream

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits of every data port.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream beat present.
REQ-005 Port: in_ready  output  1  beat accepted when in_valid and in_ready are both high at a clk edge.
REQ-006 Port: in_data  input  WIDTH  beat payload.
REQ-007 Port: in_last  input  1  beat is the final beat of its packet.
REQ-008 Port: in_sel  input  1  destination port (0 or 1); sampled only on a packet's first beat.
REQ-009 Port: out0_valid/out1_valid  output  1  output slot holds a beat.
REQ-010 Port: out0_ready/out1_ready  input  1  downstream accepts the beat.
REQ-011 Port: out0_data/out1_data  output  WIDTH  payload of the held beat.
REQ-012 Port: out0_last/out1_last  output  1  last flag of the held beat.
REQ-013 Port: pkt_cnt0/pkt_cnt1  output  8  count of packets completed into each port, modulo 256.

Function
REQ-014 State machine: IDLE (no packet open), ROUTE0 (packet locked to port 0), ROUTE1 (packet locked to port 1).
REQ-015 Target port: in IDLE it is in_sel; in ROUTE0 it is 0; in ROUTE1 it is 1.
REQ-016 in_ready = target slot empty OR target outN_ready high; in_ready does not depend on in_valid.
REQ-017 An accepted beat is written into the target slot; outN_valid/data/last appear on the next cycle (latency 1).
REQ-018 IDLE -> ROUTEn when an accepted beat has in_last=0, where n = in_sel.
REQ-019 IDLE stays IDLE when an accepted beat has in_last=1 (single-beat packet).
REQ-020 ROUTEn -> IDLE on an accepted beat with in_last=1; otherwise ROUTEn holds.
REQ-021 in_sel changes while in ROUTEn are ignored.
REQ-022 Slot drain: when outN_valid and outN_ready are both high, the slot empties unless it is refilled in the same cycle. Simultaneous drain and fill gives full throughput of 1 beat/cycle per port.
REQ-023 The non-target slot drains independently, with no interaction with the input side.
REQ-024 outN_data and outN_last hold stable while outN_valid=1 and outN_ready=0.
REQ-025 pkt_cntN increments by 1 when a beat with in_last=1 is accepted into port N; it wraps 255 -> 0.
REQ-026 A beat is never duplicated, dropped or reordered within a port.

Reset
REQ-027 While rst=1: state=IDLE, out0_valid=out1_valid=0, out0_last=out1_last=0, outN_data=0, pkt_cnt0=pkt_cnt1=0, in_ready=1.
REQ-028 Reset asserted mid-packet discards any open packet and slot contents. The first accepted beat after release starts a new packet.
REQ-029 Nothing is accepted on the clk edge where rst is high.

Structure
REQ-030 Shared package demux_pkg holds the state enum (IDLE, ROUTE0, ROUTE1) and the counter width constant (8).
REQ-031 One sub-module, demux_out_slot (one-entry register slice: valid/data/last, fill and drain), is instantiated twice.
REQ-032 The FSM, target/in_ready logic and packet counters live in the top module.

Verification
REQ-033 Single-beat packet: in_sel=1, in_data=0xA5, in_last=1, out1_ready=1 -> next cycle out1_valid=1, out1_data=0xA5, out1_last=1; out0_valid stays 0; pkt_cnt1=1; state stays IDLE.
REQ-034 Locked routing: 3-beat packet 0x11,0x22,0x33 with in_sel=0 on beat 1 and in_sel=1 on beats 2-3 -> all three beats appear on out0 in order, last=1 only on 0x33; pkt_cnt0=1.
REQ-035 Backpressure: out0_ready=0, send 2 beats to port 0 -> first beat is accepted; in_ready=0 on the second; out0_data holds the first beat. Raise out0_ready -> second beat is accepted that cycle and appears next cycle.
REQ-036 Independence: out0 stalled and full, new packet with in_sel=1 -> in_ready=1 and the beat reaches out1 at latency 1.
REQ-037 Wrap: 256 single-beat packets to port 0 -> pkt_cnt0 returns to 0; pkt_cnt1 unchanged.
REQ-038 Reset mid-packet: assert rst after beat 2 of a 4-beat packet to port 1 -> all outputs and counters reach their reset values immediately. After release, a beat with in_sel=0, in_last=1 goes to out0.
